// File: rtl/adc_sequencer_if.sv
// adc_sequencer_if -- register bus plus serial-engine command/result channel
// for the ADC sequencer.
//   addr/data_in/wr/rd/data_out : single-cycle register access, registered read
//   cmd_valid/cmd_word/cmd_ready: command handshake towards the serial ADC engine
//   res_valid/res_data          : conversion result, res_data[15:13] = channel
//   busy/overflow               : sequencer status
// master: the bus host / serial engine side.  slave: the sequencer itself.
interface adc_sequencer_if;
  logic [18:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        cmd_valid;
  logic [15:0] cmd_word;
  logic        cmd_ready;
  logic        res_valid;
  logic [15:0] res_data;
  logic        busy;
  logic        overflow;

  modport master (
    output addr, data_in, wr, rd, cmd_ready, res_valid, res_data,
    input  data_out, cmd_valid, cmd_word, busy, overflow
  );

  modport slave (
    input  addr, data_in, wr, rd, cmd_ready, res_valid, res_data,
    output data_out, cmd_valid, cmd_word, busy, overflow
  );
endinterface

// File: rtl/adc_sequencer.sv
// adc_sequencer -- scans the channels enabled in MASK at a rate set by DIV,
// issues one command per channel to a serial ADC engine and queues results
// in a FIFO readable over the register bus.
// Ports:
//   clk   : system clock, everything on posedge
//   reset : asynchronous, active-high
//   bus   : adc_sequencer_if.slave (register bus, command/result channel, status)
// Registers at BASE = POSITION<<8:
//   +0x10 CTRL {single_shot, enable}, +0x11 MASK[7:0], +0x12 DIV,
//   +0x13 FIFO pop (read), +0x14 STATUS {overflow, timeout_err, busy, 6'b0, count[6:0]}
// Optional feature: define ADC_SEQ_TIMEOUT_EN to abandon a result after 256
// cycles in WAIT_RES and set the sticky timeout_err flag.
module adc_sequencer #(
  parameter int POSITION   = 0,
  parameter int FIFO_DEPTH = 16
) (
  input logic             clk,
  input logic             reset,
  adc_sequencer_if.slave  bus
);
  localparam logic [18:0] BASE   = 19'(POSITION << 8);
  localparam logic [18:0] A_CTRL = BASE + 19'h10;
  localparam logic [18:0] A_MASK = BASE + 19'h11;
  localparam logic [18:0] A_DIV  = BASE + 19'h12;
  localparam logic [18:0] A_POP  = BASE + 19'h13;
  localparam logic [18:0] A_STAT = BASE + 19'h14;
  localparam int          AW     = $clog2(FIFO_DEPTH);
  localparam logic [6:0]  DEPTH  = 7'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_TICK, ISSUE, WAIT_RES} state_t;

  state_t        state_q;
  logic          en_q, single_q, started_q, ovf_q, tmo_q, cmd_valid_q;
  logic [7:0]    mask_q;
  logic [15:0]   div_q, div_act_q, tick_cnt_q, data_out_q, cmd_word_q;
  logic [2:0]    ch_q;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [6:0]    count_q;

  // Next set mask bit at or after 'start', ascending with wrap 7->0.
  function automatic logic [2:0] next_ch(input logic [7:0] m, input logic [2:0] start);
    logic [2:0] c;
    logic       found;
    next_ch = 3'd0;
    found   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      c = start + 3'(i);
      if (!found && m[c]) begin
        next_ch = c;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [2:0] top_ch(input logic [7:0] m);
    top_ch = 3'd0;
    for (int i = 0; i < 8; i++) if (m[i]) top_ch = 3'(i);
  endfunction

  logic       wr_ctrl, wr_mask, wr_div, wr_stat, rd_pop;
  logic       tick, push_req, push, pop, full, ovf_set, timeout_hit, res_done;
  logic [2:0] sel_ch_d;

  assign wr_ctrl  = bus.wr && (bus.addr == A_CTRL);
  assign wr_mask  = bus.wr && (bus.addr == A_MASK);
  assign wr_div   = bus.wr && (bus.addr == A_DIV);
  assign wr_stat  = bus.wr && (bus.addr == A_STAT);
  assign rd_pop   = bus.rd && (bus.addr == A_POP);

  assign tick     = en_q && (tick_cnt_q == div_act_q);
  assign full     = (count_q == DEPTH);
  assign pop      = rd_pop && (count_q != 7'd0);
  assign push_req = (state_q == WAIT_RES) && bus.res_valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign res_done = push_req || timeout_hit;
  // The search restarts from channel 0 inclusive after every IDLE visit.
  assign sel_ch_d = next_ch(mask_q, started_q ? ch_q + 3'd1 : 3'd0);

`ifdef ADC_SEQ_TIMEOUT_EN
  logic [7:0] to_cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    to_cnt_q <= 8'd0;
    else if (state_q != WAIT_RES) to_cnt_q <= 8'd0;
    else                          to_cnt_q <= to_cnt_q + 8'd1;
  end
  // to_cnt_q == 255 marks the 256th cycle spent in WAIT_RES.
  assign timeout_hit = (state_q == WAIT_RES) && !bus.res_valid && (to_cnt_q == 8'hFF);
`else
  assign timeout_hit = 1'b0;
`endif

  // Tick divider; a DIV write is picked up only when the count restarts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= 16'd0;
      div_act_q  <= 16'd0;
    end else if (!en_q || tick) begin
      tick_cnt_q <= 16'd0;
      div_act_q  <= div_q;
    end else begin
      tick_cnt_q <= tick_cnt_q + 16'd1;
    end
  end

  // FIFO storage kept reset-free so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.res_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      en_q        <= 1'b0;
      single_q    <= 1'b0;
      started_q   <= 1'b0;
      mask_q      <= 8'd0;
      div_q       <= 16'd0;
      ch_q        <= 3'd0;
      ovf_q       <= 1'b0;
      tmo_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_word_q  <= 16'd0;
      data_out_q  <= 16'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= 7'd0;
    end else begin
      case (state_q)
        IDLE: begin
          started_q <= 1'b0;
          if (en_q && mask_q != 8'd0) state_q <= WAIT_TICK;
        end
        WAIT_TICK: begin
          if (!en_q || mask_q == 8'd0) begin
            state_q <= IDLE;
          end else if (tick) begin
            ch_q        <= sel_ch_d;
            started_q   <= 1'b1;
            cmd_valid_q <= 1'b1;
            cmd_word_q  <= 16'h8030 | {3'b000, sel_ch_d, 10'd0};
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (res_done) begin
            if (!en_q || mask_q == 8'd0) begin
              state_q <= IDLE;
            end else if (single_q && ch_q == top_ch(mask_q)) begin
              en_q    <= 1'b0;
              state_q <= IDLE;
            end else begin
              state_q <= WAIT_TICK;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      // Host writes come after the FSM so a CTRL write wins over the
      // single-shot auto-clear in the same cycle.
      if (wr_ctrl) begin
        en_q     <= bus.data_in[0];
        single_q <= bus.data_in[1];
      end
      if (wr_mask) mask_q <= bus.data_in[7:0];
      if (wr_div)  div_q  <= bus.data_in;
      if (wr_stat && bus.data_in[15]) ovf_q <= 1'b0;
      if (wr_stat && bus.data_in[14]) tmo_q <= 1'b0;
      if (ovf_set)     ovf_q <= 1'b1;
      if (timeout_hit) tmo_q <= 1'b1;

      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + 7'd1;
      else if (pop && !push) count_q <= count_q - 7'd1;

      if (bus.rd) begin
        case (bus.addr)
          A_CTRL:  data_out_q <= {14'd0, single_q, en_q};
          A_MASK:  data_out_q <= {8'd0, mask_q};
          A_DIV:   data_out_q <= div_q;
          A_POP:   data_out_q <= pop ? mem[rd_ptr_q] : 16'd0;
          A_STAT:  data_out_q <= {ovf_q, tmo_q, (state_q != IDLE), 6'd0, count_q};
          default: data_out_q <= 16'd0;
        endcase
      end
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_word  = cmd_word_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_adc_sequencer.sv
module tb_adc_sequencer;
  localparam logic [18:0] A_CTRL = 19'h110;
  localparam logic [18:0] A_MASK = 19'h111;
  localparam logic [18:0] A_DIV  = 19'h112;
  localparam logic [18:0] A_POP  = 19'h113;
  localparam logic [18:0] A_STAT = 19'h114;

  logic clk = 1'b0;
  logic reset;
  adc_sequencer_if bus();

  adc_sequencer #(.POSITION(1), .FIFO_DEPTH(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          seq    = 1;
  logic        auto_resp = 1'b0;
  logic [2:0]  resp_ch;
  logic [15:0] cmd_log[$];
  int          cyc_log[$];
  logic [15:0] rdata;

  always @(posedge clk) cyc <= cyc + 1;

  // Serial-engine model: logs each accepted command (sampled 1 ns before the
  // accepting edge) and, when enabled, returns a result 2 cycles later.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) begin
        cmd_log.push_back(bus.cmd_word);
        cyc_log.push_back(cyc);
        $display("cmd accept word=%h cycle=%0d", bus.cmd_word, cyc);
        if (auto_resp) begin
          resp_ch = bus.cmd_word[12:10];
          @(negedge clk);
          @(negedge clk);
          bus.res_valid = 1'b1;
          bus.res_data  = {resp_ch, 13'(seq)};
          seq++;
          @(negedge clk);
          bus.res_valid = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic bus_write(input logic [18:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.addr = a; bus.data_in = d; bus.wr = 1'b1;
    @(negedge clk);
    bus.wr = 1'b0;
    $display("write addr=%h data=%h", a, d);
  endtask

  task automatic bus_read(input logic [18:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.addr = a; bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
    d = bus.data_out;
    $display("read addr=%h data=%h", a, d);
  endtask

  task automatic wait_busy(input logic val, input string tag);
    int n = 0;
    while (bus.busy !== val && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {15'd0, bus.busy}, {15'd0, val});
  endtask

  task automatic wait_cmds(input int num, input string tag);
    int n = 0;
    while (cmd_log.size() < num && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 16'(cmd_log.size()), 16'(num));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    auto_resp = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.res_valid = 1'b0;
    repeat (2) @(negedge clk);
    cmd_log.delete();
    cyc_log.delete();
    seq = 1;
    reset = 1'b0;
  endtask

  initial begin
    int n;
    bus.addr = '0; bus.data_in = '0; bus.wr = 1'b0; bus.rd = 1'b0;
    bus.cmd_ready = 1'b0; bus.res_valid = 1'b0; bus.res_data = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_data_out", bus.data_out, 16'h0000);
    chk("rst_cmd_valid", {15'd0, bus.cmd_valid}, 16'h0000);
    chk("rst_cmd_word", bus.cmd_word, 16'h0000);
    chk("rst_busy", {15'd0, bus.busy}, 16'h0000);
    chk("rst_overflow", {15'd0, bus.overflow}, 16'h0000);
    reset = 1'b0;
    bus_read(A_STAT, rdata); chk("rst_status", rdata, 16'h0000);
    bus_read(A_CTRL, rdata); chk("rst_ctrl", rdata, 16'h0000);

    // Register access and address decode at BASE=0x100
    bus_write(A_DIV, 16'h1234);
    bus_read(A_DIV, rdata);    chk("div_rdback", rdata, 16'h1234);
    bus_read(19'h012, rdata);  chk("unmapped_rd", rdata, 16'h0000);
    bus_write(A_MASK, 16'h00A5);
    bus_read(A_MASK, rdata);   chk("mask_rdback", rdata, 16'h00A5);

    // res_valid while idle is ignored
    @(negedge clk); bus.res_valid = 1'b1; bus.res_data = 16'hBEEF;
    @(negedge clk); bus.res_valid = 1'b0;
    bus_read(A_STAT, rdata);   chk("idle_res_ignored", rdata, 16'h0000);

    // Continuous scan MASK=0x05, DIV=3
    do_reset();
    bus_write(A_DIV, 16'd3);
    bus_write(A_MASK, 16'h0005);
    bus.cmd_ready = 1'b1; auto_resp = 1'b1;
    bus_write(A_CTRL, 16'h0001);
    wait_cmds(4, "scan_ncmd");
    chk("scan_cmd0", cmd_log[0], 16'h8030);
    chk("scan_cmd1", cmd_log[1], 16'h8830);
    chk("scan_cmd2", cmd_log[2], 16'h8030);
    chk("scan_cmd3", cmd_log[3], 16'h8830);
    for (int i = 0; i < 3; i++)
      chk("scan_gap_ge4", 16'((cyc_log[i+1] - cyc_log[i]) >= 4), 16'd1);
    bus_write(A_CTRL, 16'h0000);
    wait_busy(1'b0, "scan_stop_idle");
    bus_read(A_POP, rdata);    chk("scan_pop0", rdata, 16'h0001);
    bus_read(A_POP, rdata);    chk("scan_pop1", rdata, 16'h4002);

    // Single-shot MASK=0x81
    do_reset();
    bus_write(A_DIV, 16'd0);
    bus_write(A_MASK, 16'h0081);
    bus.cmd_ready = 1'b1; auto_resp = 1'b1;
    bus_write(A_CTRL, 16'h0003);
    wait_busy(1'b1, "ss_busy_up");
    wait_busy(1'b0, "ss_busy_fall");
    repeat (5) @(negedge clk);
    chk("ss_ncmd", 16'(cmd_log.size()), 16'd2);
    chk("ss_cmd0", cmd_log[0], 16'h8030);
    chk("ss_cmd1", cmd_log[1], 16'h9C30);
    bus_read(A_STAT, rdata);   chk("ss_status", rdata, 16'h0002);
    bus_read(A_CTRL, rdata);   chk("ss_ctrl_en_clr", rdata, 16'h0002);
    bus_read(A_POP, rdata);    chk("ss_pop0", rdata, 16'h0001);
    bus_read(A_POP, rdata);    chk("ss_pop1", rdata, 16'hE002);
    bus_read(A_POP, rdata);    chk("ss_pop_empty", rdata, 16'h0000);
    bus_read(A_STAT, rdata);   chk("ss_status_empty", rdata, 16'h0000);

    // cmd_ready held low: word stays stable, one accept
    do_reset();
    bus_write(A_DIV, 16'd0);
    bus_write(A_MASK, 16'h0008);
    auto_resp = 1'b1;
    bus_write(A_CTRL, 16'h0003);
    n = 0;
    while (bus.cmd_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("hold_valid_up", {15'd0, bus.cmd_valid}, 16'd1);
    repeat (10) begin
      @(negedge clk);
      chk("hold_word", bus.cmd_word, 16'h8C30);
    end
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    chk("hold_valid_drop", {15'd0, bus.cmd_valid}, 16'd0);
    wait_busy(1'b0, "hold_done");
    chk("hold_ncmd", 16'(cmd_log.size()), 16'd1);
    chk("hold_cmd0", cmd_log[0], 16'h8C30);
    bus_read(A_POP, rdata);    chk("hold_pop", rdata, 16'h6001);

    // FIFO overflow with 17 results, then full push with simultaneous pop
    do_reset();
    bus_write(A_DIV, 16'd0);
    bus_write(A_MASK, 16'h0001);
    bus.cmd_ready = 1'b1; auto_resp = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus_write(A_CTRL, 16'h0003);
      wait_busy(1'b1, "ovf_busy_up");
      wait_busy(1'b0, "ovf_busy_fall");
    end
    bus_read(A_STAT, rdata);   chk("ovf_status", rdata, 16'h8010);
    chk("ovf_flag", {15'd0, bus.overflow}, 16'd1);
    bus_read(A_POP, rdata);    chk("ovf_head", rdata, 16'h0001);
    bus_read(A_STAT, rdata);   chk("ovf_status15", rdata, 16'h800F);
    bus_write(A_STAT, 16'h8000);
    bus_read(A_STAT, rdata);   chk("ovf_cleared", rdata, 16'h000F);
    bus_write(A_CTRL, 16'h0003);
    wait_busy(1'b1, "refill_busy_up");
    wait_busy(1'b0, "refill_busy_fall");
    bus_read(A_STAT, rdata);   chk("refill_status", rdata, 16'h0010);
    auto_resp = 1'b0;
    bus_write(A_CTRL, 16'h0003);
    n = 0;
    while (bus.cmd_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.res_valid = 1'b1; bus.res_data = 16'h1ABC;
    bus.addr = A_POP; bus.rd = 1'b1;
    @(negedge clk);
    bus.res_valid = 1'b0; bus.rd = 1'b0;
    chk("pushpop_data", bus.data_out, 16'h0002);
    chk("pushpop_no_ovf", {15'd0, bus.overflow}, 16'd0);
    wait_busy(1'b0, "pushpop_done");
    bus_read(A_STAT, rdata);   chk("pushpop_status", rdata, 16'h0010);

    // Enable cleared in WAIT_TICK goes idle next cycle
    do_reset();
    bus_write(A_DIV, 16'h00FF);
    bus_write(A_MASK, 16'h0001);
    bus_write(A_CTRL, 16'h0001);
    wait_busy(1'b1, "wt_busy_up");
    repeat (3) @(negedge clk);
    bus_write(A_CTRL, 16'h0000);
    @(negedge clk);
    chk("wt_idle", {15'd0, bus.busy}, 16'd0);
    chk("wt_no_cmd", 16'(cmd_log.size()), 16'd0);

    // No result returned from the engine
    do_reset();
    bus_write(A_DIV, 16'd0);
    bus_write(A_MASK, 16'h0003);
    bus.cmd_ready = 1'b1;
    bus_write(A_CTRL, 16'h0001);
    wait_cmds(1, "tmo_first_cmd");
    repeat (300) @(negedge clk);
    bus_read(A_STAT, rdata);
`ifdef ADC_SEQ_TIMEOUT_EN
    chk("tmo_ncmd", 16'(cmd_log.size()), 16'd2);
    chk("tmo_cmd1", cmd_log[1], 16'h8430);
    chk("tmo_status", rdata & 16'h407F, 16'h4000);
    bus_write(A_CTRL, 16'h0000);
    wait_busy(1'b0, "tmo_idle");
    bus_write(A_STAT, 16'h4000);
    bus_read(A_STAT, rdata);   chk("tmo_cleared", rdata, 16'h0000);
`else
    chk("notmo_ncmd", 16'(cmd_log.size()), 16'd1);
    chk("notmo_status", rdata & 16'h607F, 16'h2000);
    bus_write(A_CTRL, 16'h0000);
    @(negedge clk); bus.res_valid = 1'b1; bus.res_data = 16'h2222;
    @(negedge clk); bus.res_valid = 1'b0;
    wait_busy(1'b0, "notmo_idle");
    bus_read(A_STAT, rdata);   chk("notmo_status_end", rdata, 16'h0001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
